// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Holds the width helpers used to size the count and pointers, and the
// read-mode enumeration that selects registered or fall-through output.
package fifo_pkg;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  // Width needed to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to address 0..depth-1; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and the FIFO (slave).
// master: drives wr_en, data_in, rd_en; observes data_out, data_valid,
//         wr_ack, overflow, underflow, full, empty, almostfull,
//         almostempty, count.
// slave:  the reverse.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// FIFO storage: WIDTH x DEPTH array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered or first-word-fall-through
// read, write/overflow/underflow status pulses and occupancy flags.
// Ports: clk, rst_n (async, active low), bus (slave side of
//        sync_fifo_param_if carrying the write/read handshake and status).
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam fwft_mode_e    MODE     = (FWFT != 0) ? FWFT_ON : FWFT_OFF;

  if (FIFO_WIDTH < 1 || FIFO_WIDTH > 64) begin : g_bad_width
    $error("FIFO_WIDTH must be 1..64");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
    $error("AF_LEVEL must be 1..FIFO_DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("AE_LEVEL must be 1..FIFO_DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("FWFT must be 0 or 1");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  is_full, is_empty;
  logic                  rd_ok, wr_ok;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);
  assign rd_ok    = bus.rd_en && !is_empty;
  // A read freeing a slot lets a write at full pass through in the same cycle.
  assign wr_ok    = bus.wr_en && (!is_full || rd_ok);

  fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      bus.wr_ack    <= wr_ok;
      bus.overflow  <= bus.wr_en && !wr_ok;
      bus.underflow <= bus.rd_en && !rd_ok;
    end
  end

  if (MODE == FWFT_ON) begin : g_fwft
    assign bus.data_out   = ram_rdata;
    assign bus.data_valid = !is_empty;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bus.data_out   <= '0;
        bus.data_valid <= 1'b0;
      end else begin
        bus.data_valid <= rd_ok;
        if (rd_ok) bus.data_out <= ram_rdata;
      end
    end
  end

  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almostfull  = (cnt >= AF_C);
  assign bus.almostempty = (cnt <= AE_C) && !is_empty;
  assign bus.count       = cnt;

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= DEPTH_C);
  a_pass_full: assert property (@(posedge clk) disable iff (!rst_n)
    (is_full && bus.wr_en && bus.rd_en) |=> (bus.wr_ack && cnt == DEPTH_C));
  a_empty_rw: assert property (@(posedge clk) disable iff (!rst_n)
    (is_empty && bus.wr_en && bus.rd_en) |=> (bus.wr_ack && bus.underflow && cnt == CW'(1)));
  a_cnt_inc: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_ok && !rd_ok) |=> (cnt == $past(cnt) + CW'(1)));
  a_cnt_dec: assert property (@(posedge clk) disable iff (!rst_n)
    (!wr_ok && rd_ok) |=> (cnt == $past(cnt) - CW'(1)));
  a_wr_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_ok && wr_ptr == LAST_PTR) |=> (wr_ptr == '0));
  a_rd_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (rd_ok && rd_ptr == LAST_PTR) |=> (rd_ptr == '0));
  a_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wr_en && !wr_ok) |=> bus.overflow);

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int W = 16;

  typedef logic [W-1:0] word_q_t[$];

  typedef struct packed {
    logic [W-1:0] dout;
    logic         dv;
    logic         ack;
    logic         ovf;
    logic         unf;
    logic         full;
    logic         empty;
    logic         af;
    logic         ae;
    logic [3:0]   cnt;
  } obs_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_in = '0;

  always #5 clk = ~clk;

  // A: depth 8, defaults. B: depth 5 registered. C: depth 5 fall-through.
  sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) a_if ();
  sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) b_if ();
  sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) c_if ();

  assign a_if.wr_en = wr_en; assign a_if.rd_en = rd_en; assign a_if.data_in = data_in;
  assign b_if.wr_en = wr_en; assign b_if.rd_en = rd_en; assign b_if.data_in = data_in;
  assign c_if.wr_en = wr_en; assign c_if.rd_en = rd_en; assign c_if.data_in = data_in;

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if));
  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if));
  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if));

  obs_t obs [3];
  assign obs[0] = {a_if.data_out, a_if.data_valid, a_if.wr_ack, a_if.overflow, a_if.underflow,
                   a_if.full, a_if.empty, a_if.almostfull, a_if.almostempty, 4'(a_if.count)};
  assign obs[1] = {b_if.data_out, b_if.data_valid, b_if.wr_ack, b_if.overflow, b_if.underflow,
                   b_if.full, b_if.empty, b_if.almostfull, b_if.almostempty, 4'(b_if.count)};
  assign obs[2] = {c_if.data_out, c_if.data_valid, c_if.wr_ack, c_if.overflow, c_if.underflow,
                   c_if.full, c_if.empty, c_if.almostfull, c_if.almostempty, 4'(c_if.count)};

  // Reference model: one queue per FIFO plus the registered status it implies.
  word_q_t      qa, qb, qc;
  logic [W-1:0] exp_dout [3];
  bit           exp_dv  [3];
  bit           exp_ack [3];
  bit           exp_ovf [3];
  bit           exp_unf [3];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input int depth, input bit fwft,
                            input bit we, input bit re, input logic [W-1:0] din,
                            ref word_q_t q);
    bit rd_ok, wr_ok;
    rd_ok = re && (q.size() > 0);
    wr_ok = we && ((q.size() < depth) || rd_ok);
    if (rd_ok) begin
      if (!fwft) exp_dout[d] = q[0];
      q.delete(0);
    end
    if (wr_ok) q.push_back(din);
    exp_ack[d] = wr_ok;
    exp_ovf[d] = we && !wr_ok;
    exp_unf[d] = re && !rd_ok;
    exp_dv[d]  = fwft ? (q.size() > 0) : rd_ok;
    if (fwft && q.size() > 0) exp_dout[d] = q[0];
  endtask

  task automatic compare(input int d, input int depth, input int af, input int ae,
                         input bit fwft, input int n);
    string p;
    p = $sformatf("dut%0d", d);
    check_eq({p, " count"},       32'(obs[d].cnt),   32'(n));
    check_eq({p, " full"},        32'(obs[d].full),  32'(n == depth));
    check_eq({p, " empty"},       32'(obs[d].empty), 32'(n == 0));
    check_eq({p, " almostfull"},  32'(obs[d].af),    32'(n >= af));
    check_eq({p, " almostempty"}, 32'(obs[d].ae),    32'(n <= ae && n != 0));
    check_eq({p, " wr_ack"},      32'(obs[d].ack),   32'(exp_ack[d]));
    check_eq({p, " overflow"},    32'(obs[d].ovf),   32'(exp_ovf[d]));
    check_eq({p, " underflow"},   32'(obs[d].unf),   32'(exp_unf[d]));
    check_eq({p, " data_valid"},  32'(obs[d].dv),    32'(exp_dv[d]));
    if (!fwft || n > 0)
      check_eq({p, " data_out"},  32'(obs[d].dout),  32'(exp_dout[d]));
  endtask

  task automatic compare_all();
    compare(0, 8, 7, 1, 1'b0, qa.size());
    compare(1, 5, 3, 2, 1'b0, qb.size());
    compare(2, 5, 4, 1, 1'b1, qc.size());
  endtask

  // Drive one cycle's inputs, advance the models at the edge, check after it.
  task automatic step(input bit we, input bit re, input logic [W-1:0] din);
    wr_en   = we;
    rd_en   = re;
    data_in = din;
    @(posedge clk);
    model_step(0, 8, 1'b0, we, re, din, qa);
    model_step(1, 5, 1'b0, we, re, din, qb);
    model_step(2, 5, 1'b1, we, re, din, qc);
    #1;
    compare_all();
  endtask

  // Reset lands mid-cycle so the outputs must clear without a clock edge.
  task automatic apply_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete(); qc.delete();
    for (int d = 0; d < 3; d++) begin
      exp_dout[d] = '0; exp_dv[d] = 1'b0; exp_ack[d] = 1'b0;
      exp_ovf[d]  = 1'b0; exp_unf[d] = 1'b0;
    end
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    int wp, rp;
    #1;
    apply_reset();

    // Fall-through word visible the cycle after the write, no read needed.
    step(1'b1, 1'b0, 16'h1234);
    check_eq("fwft data_out", 32'(c_if.data_out), 32'h1234);
    check_eq("fwft data_valid", 32'(c_if.data_valid), 32'd1);
    step(1'b0, 1'b1, '0);

    // Empty with simultaneous write and read.
    step(1'b1, 1'b1, 16'h0055);
    check_eq("empty rw count", 32'(a_if.count), 32'd1);
    check_eq("empty rw underflow", 32'(a_if.underflow), 32'd1);
    check_eq("empty rw wr_ack", 32'(a_if.wr_ack), 32'd1);
    check_eq("empty rw data_valid", 32'(a_if.data_valid), 32'd0);
    step(1'b0, 1'b1, '0);
    check_eq("empty rw readback", 32'(a_if.data_out), 32'h0055);

    // Fill depth-8 FIFO, then one write too many.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, W'(i));
    check_eq("fill full", 32'(a_if.full), 32'd1);
    check_eq("fill count", 32'(a_if.count), 32'd8);
    step(1'b1, 1'b0, 16'h0099);
    check_eq("fill overflow", 32'(a_if.overflow), 32'd1);

    // Pass-through at full.
    step(1'b1, 1'b1, 16'h00AA);
    check_eq("pass count", 32'(a_if.count), 32'd8);
    check_eq("pass wr_ack", 32'(a_if.wr_ack), 32'd1);
    check_eq("pass first out", 32'(a_if.data_out), 32'h0001);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    check_eq("pass last out", 32'(a_if.data_out), 32'h00AA);

    // Interleaved traffic wrapping the depth-5 pointers.
    apply_reset();
    for (int i = 0; i < 12; i++) step(1'b1, (i % 3) != 0, W'(16'h0100 + i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);

    // Randomised phases: fill-biased, drain-biased, balanced.
    for (int i = 0; i < 900; i++) begin
      case ((i / 100) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      step($urandom_range(99) < wp, $urandom_range(99) < rp, W'($urandom));
    end

    // Reset while holding three words.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom));
    check_eq("pre-reset count", 32'(a_if.count), 32'd3);
    apply_reset();
    check_eq("post-reset empty", 32'(a_if.empty), 32'd1);

    for (int i = 0; i < 300; i++)
      step($urandom_range(99) < 55, $urandom_range(99) < 50, W'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
